adc_cfg_seq: RTL and testbench
==============================

ADC_CFG_SEQ -- requirements
Module: adc_cfg_seq

Interface
REQ-001 Parameter NUM_REGS, default 8: entries in the power-up register table (1..16).
REQ-002 Parameter TMO_CYCLES, default 64: maximum clk cycles from init_conf to end_conf before timeout.
REQ-003 Parameter GAP_CYCLES, default 2: minimum idle cycles between consecutive serial transfers (CS high time).
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock, all logic on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  single-cycle pulse: run the whole power-up table.
REQ-008 tbl_addr  out  4  table read index.
REQ-009 tbl_data  in  24  table word, valid one cycle after tbl_addr changes (synchronous ROM).
REQ-010 host_req  in  1  slow-control single-write request, level, held until host_ack.
REQ-011 host_word  in  24  slow-control word, stable while host_req high.
REQ-012 host_ack  out  1  single-cycle pulse when host_word has been captured.
REQ-013 init_conf  out  1  single-cycle pulse starting one 24-bit serial transfer.
REQ-014 cfg_word  out  24  word to serialize, stable from init_conf until end_conf.
REQ-015 end_conf  in  1  single-cycle pulse from the serializer: transfer complete.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  single-cycle pulse after the last table entry or host write completes.
REQ-018 err  out  1  sticky timeout flag, cleared only by rst or by the next accepted start.

Function
REQ-019 States: IDLE, TBL_RD, ISSUE, WAIT, GAP, FINISH.
REQ-020 IDLE: start -> TBL_RD with index 0; else host_req -> capture host_word into cfg_word, pulse host_ack, -> ISSUE; start and host_req in the same cycle: start wins, host stays pending.
REQ-021 TBL_RD: drive tbl_addr = index for one cycle, capture tbl_data into cfg_word on the following cycle, -> ISSUE.
REQ-022 ISSUE: init_conf = 1 for exactly one cycle, clear timeout counter, -> WAIT.
REQ-023 WAIT: end_conf -> GAP; timeout counter reaching TMO_CYCLES-1 without end_conf -> set err, -> FINISH without further transfers.
REQ-024 GAP: hold GAP_CYCLES cycles; then table mode with index < NUM_REGS-1 -> increment index, -> TBL_RD; otherwise -> FINISH.
REQ-025 FINISH: done = 1 for one cycle (also on timeout abort), -> IDLE.
REQ-026 host_req and start are ignored while busy; a table run is never interleaved with host writes.
REQ-027 end_conf outside WAIT is ignored; start outside IDLE is ignored.
REQ-028 Index counter 4 bits, never wraps: last index is NUM_REGS-1.
REQ-029 Timeout counter width ceil(log2(TMO_CYCLES))+1, saturates.

Reset
REQ-030 On rst: state IDLE, tbl_addr 0, cfg_word 0, init_conf 0, host_ack 0, busy 0, done 0, err 0, all counters 0.
REQ-031 rst mid-transfer aborts immediately with no done pulse; serializer recovers on its own reset.

Structure
REQ-032 State encodings and default parameter constants live in shared package adc_cfg_pkg.
REQ-033 Single module, no sub-modules; the downstream serializer is instantiated by the parent.

Verification
REQ-034 start, NUM_REGS=3, table {0x000800,0x001403,0x00FF01}, end_conf 24 cycles after each init_conf -> three init_conf pulses, cfg_word in order, >=2 idle cycles between, one done, err=0.
REQ-035 host_req with host_word 0x000D04 in IDLE -> host_ack next cycle, one init_conf with cfg_word 0x000D04, done after end_conf + GAP.
REQ-036 start and host_req same cycle -> full table runs first, host_ack only after return to IDLE, then host write.
REQ-037 end_conf withheld, TMO_CYCLES=64 -> err set 64 cycles after init_conf, done pulses, no further init_conf; next start clears err.
REQ-038 rst asserted during WAIT of entry 1 -> all outputs reset values within the same cycle, no done pulse.
REQ-039 spurious end_conf in IDLE and GAP -> no state change.

Source files
------------

// File: rtl/adc_cfg_pkg.sv
// adc_cfg_pkg
// Shared definitions for the ADC configuration sequencer: FSM state
// encoding, default parameter values, datapath widths and a small helper
// for sizing counters.
package adc_cfg_pkg;

  // Default values for the sequencer parameters.
  localparam int unsigned DEF_NUM_REGS   = 8;
  localparam int unsigned DEF_TMO_CYCLES = 64;
  localparam int unsigned DEF_GAP_CYCLES = 2;

  // Datapath widths.
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned WORD_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TBL_RD = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_GAP    = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  // Width of a counter that must be able to reach n, plus one spare bit
  // so that saturation can never be confused with a terminal count.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/adc_cfg_seq.sv
// adc_cfg_seq
// Power-up / slow-control configuration sequencer for an ADC. On start it
// walks a synchronous-ROM register table and issues one 24-bit serial
// transfer per entry; in IDLE it can instead forward a single host write.
// Each transfer is started with init_conf and finished by end_conf from
// the downstream serializer, followed by a minimum chip-select-high gap.
// A transfer that never completes raises a sticky err and aborts the run.
//
// State table:
//   state  | meaning
//   IDLE   | waiting for start (table run) or host_req (single write)
//   TBL_RD | two cycles: present tbl_addr, then capture tbl_data
//   ISSUE  | init_conf pulse, timeout counter starts from zero
//   WAIT   | waiting for end_conf or timeout
//   GAP    | GAP_CYCLES idle cycles between transfers
//   FINISH | done pulse, back to IDLE
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   start             pulse: run the whole register table
//   tbl_addr/tbl_data table index out, table word in (one-cycle latency)
//   host_req/word/ack slow-control single-write handshake
//   init_conf         pulse: start one serial transfer of cfg_word
//   cfg_word          word being transferred
//   end_conf          pulse from serializer: transfer complete
//   busy, done, err   status: not idle, sequence finished, sticky timeout
module adc_cfg_seq
  import adc_cfg_pkg::*;
#(
  parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
  parameter int unsigned TMO_CYCLES = DEF_TMO_CYCLES,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IDX_W-1:0]  tbl_addr,
  input  logic [WORD_W-1:0] tbl_data,
  input  logic              host_req,
  input  logic [WORD_W-1:0] host_word,
  output logic              host_ack,
  output logic              init_conf,
  output logic [WORD_W-1:0] cfg_word,
  input  logic              end_conf,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned TMO_W = cnt_width(TMO_CYCLES);
  localparam int unsigned GAP_W = cnt_width(GAP_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  // A gap of zero cycles is treated as one so GAP always exits.
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((GAP_CYCLES > 1) ? (GAP_CYCLES - 1) : 0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  state_t state, state_nxt;

  logic [IDX_W-1:0] idx;
  logic             rd_phase;
  logic             tbl_mode;
  logic [TMO_W-1:0] tmo_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic run_start;
  logic ld_host;
  logic ld_tbl;
  logic set_err;
  logic idx_inc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and Moore outputs
  always_comb begin
    state_nxt = state;
    run_start = 1'b0;
    ld_host   = 1'b0;
    ld_tbl    = 1'b0;
    set_err   = 1'b0;
    idx_inc   = 1'b0;
    busy      = 1'b1;
    init_conf = 1'b0;
    done      = 1'b0;

    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        // start has priority; a simultaneous host_req stays pending
        if (start) begin
          run_start = 1'b1;
          state_nxt = ST_TBL_RD;
        end else if (host_req) begin
          ld_host   = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end

      ST_TBL_RD: begin
        // second cycle: the ROM output now reflects tbl_addr
        if (rd_phase) begin
          ld_tbl    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        init_conf = 1'b1;
        state_nxt = ST_WAIT;
      end

      ST_WAIT: begin
        if (end_conf) begin
          state_nxt = ST_GAP;
        end else if (tmo_cnt == TMO_LAST) begin
          set_err   = 1'b1;
          state_nxt = ST_FINISH;
        end
      end

      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (tbl_mode && (idx < LAST_IDX)) begin
            idx_inc   = 1'b1;
            state_nxt = ST_TBL_RD;
          end else begin
            state_nxt = ST_FINISH;
          end
        end
      end

      ST_FINISH: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: index, captured word, counters, handshake and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      rd_phase <= 1'b0;
      tbl_mode <= 1'b0;
      tmo_cnt  <= '0;
      gap_cnt  <= '0;
      cfg_word <= '0;
      host_ack <= 1'b0;
      err      <= 1'b0;
    end else begin
      host_ack <= ld_host;

      if (run_start) begin
        idx      <= '0;
        tbl_mode <= 1'b1;
      end else if (idx_inc) begin
        idx <= idx + IDX_ONE;
      end else if (ld_host) begin
        tbl_mode <= 1'b0;
      end

      rd_phase <= (state == ST_TBL_RD) && !rd_phase;

      if (ld_host) begin
        cfg_word <= host_word;
      end else if (ld_tbl) begin
        cfg_word <= tbl_data;
      end

      // An accepted start clears the sticky flag; a timeout sets it.
      if (run_start) begin
        err <= 1'b0;
      end else if (set_err) begin
        err <= 1'b1;
      end

      // Zero throughout ISSUE, so in WAIT it equals the number of cycles
      // elapsed since init_conf was asserted.
      if ((state == ST_ISSUE) || (state == ST_WAIT)) begin
        if (tmo_cnt != '1) begin
          tmo_cnt <= tmo_cnt + TMO_ONE;
        end
      end else begin
        tmo_cnt <= '0;
      end

      if (state == ST_GAP) begin
        gap_cnt <= gap_cnt + GAP_ONE;
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  assign tbl_addr = idx;

endmodule

// File: tb/tb_adc_cfg_seq.sv
// tb_adc_cfg_seq
// Bench for adc_cfg_seq (NUM_REGS=3, TMO_CYCLES=64, GAP_CYCLES=2). A
// timeline model predicts, per cycle, which outputs must be active from
// the transaction rules: a table run accepted in cycle s reads entry k in
// cycles s+1+k*P..s+2+k*P and pulses init_conf at s+3+k*P, where
// P = 3 + D + GAP and D is the serializer latency; a host write sampled in
// cycle h is acknowledged and issued at h+1; done follows the last
// end_conf after the gap. A serializer stub answers init_conf after D
// cycles. Hand-computed literals pin the model's cycle arithmetic.
module tb_adc_cfg_seq;

  localparam int NR   = 3;
  localparam int TMO  = 64;
  localparam int GAP  = 2;
  localparam int D    = 24;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  tbl_addr;
  logic [23:0] tbl_data = '0;
  logic        host_req = 1'b0;
  logic [23:0] host_word = '0;
  logic        host_ack;
  logic        init_conf;
  logic [23:0] cfg_word;
  logic        end_conf;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  adc_cfg_seq #(
    .NUM_REGS  (NR),
    .TMO_CYCLES(TMO),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tbl_addr (tbl_addr),
    .tbl_data (tbl_data),
    .host_req (host_req),
    .host_word(host_word),
    .host_ack (host_ack),
    .init_conf(init_conf),
    .cfg_word (cfg_word),
    .end_conf (end_conf),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Synchronous table ROM
  logic [23:0] rom [16];
  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 24'h0;
    rom[0] = 24'h000800;
    rom[1] = 24'h001403;
    rom[2] = 24'h00FF01;
  end
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- timeline model ----------------
  bit          e_busy [MAXC];
  bit          e_init [MAXC];
  bit          e_done [MAXC];
  bit          e_ack  [MAXC];
  bit          e_cfgv [MAXC];
  bit          e_addrv[MAXC];
  bit          e_eset [MAXC];
  bit          e_eclr [MAXC];
  logic [23:0] e_cfg  [MAXC];
  logic [3:0]  e_addr [MAXC];

  task automatic clear_from(input int c);
    for (int x = c; x < MAXC; x++) begin
      e_busy[x] = 0; e_init[x] = 0; e_done[x] = 0; e_ack[x] = 0;
      e_cfgv[x] = 0; e_addrv[x] = 0; e_eset[x] = 0; e_eclr[x] = 0;
    end
  endtask

  task automatic mark_busy(input int a, input int b);
    for (int c = a; c <= b && c < MAXC; c++) e_busy[c] = 1;
  endtask

  task automatic mark_cfg(input int a, input int b, input logic [23:0] w);
    for (int c = a; c <= b && c < MAXC; c++) begin
      e_cfgv[c] = 1;
      e_cfg[c]  = w;
    end
  endtask

  task automatic plan_table(input int s, output int fin);
    int p, i;
    p = 3 + D + GAP;
    e_eclr[s+1] = 1;
    for (int k = 0; k < NR; k++) begin
      i = s + 3 + k * p;
      e_addrv[i-2] = 1; e_addr[i-2] = 4'(k);
      e_addrv[i-1] = 1; e_addr[i-1] = 4'(k);
      e_init[i] = 1;
      mark_cfg(i, i + D, rom[k]);
    end
    fin = s + 3 + (NR - 1) * p + D + GAP + 1;
    mark_busy(s + 1, fin);
    e_done[fin] = 1;
  endtask

  task automatic plan_host(input int h, input logic [23:0] w, output int fin);
    int i;
    i = h + 1;
    e_ack[i]  = 1;
    e_init[i] = 1;
    mark_cfg(i, i + D, w);
    fin = i + D + GAP + 1;
    mark_busy(i, fin);
    e_done[fin] = 1;
  endtask

  // Entry 0 never completes: err and done appear TMO cycles after init_conf.
  task automatic plan_timeout(input int s, output int fin);
    int i;
    i = s + 3;
    e_eclr[s+1] = 1;
    e_addrv[s+1] = 1; e_addr[s+1] = 4'd0;
    e_addrv[s+2] = 1; e_addr[s+2] = 4'd0;
    e_init[i] = 1;
    mark_cfg(i, i + TMO - 1, rom[0]);
    fin = i + TMO;
    e_eset[fin] = 1;
    e_done[fin] = 1;
    mark_busy(s + 1, fin);
  endtask

  bit model_err = 0;
  always @(negedge clk) begin
    if (rst) begin
      model_err = 0;
    end else if (chk_en && cyc < MAXC) begin
      if (e_eclr[cyc]) model_err = 0;
      if (e_eset[cyc]) model_err = 1;
      check("busy", busy, e_busy[cyc]);
      check("init_conf", init_conf, e_init[cyc]);
      check("done", done, e_done[cyc]);
      check("host_ack", host_ack, e_ack[cyc]);
      check("err", err, model_err);
      if (e_cfgv[cyc])  check("cfg_word", cfg_word, e_cfg[cyc]);
      if (e_addrv[cyc]) check("tbl_addr", tbl_addr, e_addr[cyc]);
    end
  end

  // ---------------- serializer stub ----------------
  int   pend     = -1;
  bit   stub_en  = 1;
  logic stub_end = 1'b0;
  logic spur_end = 1'b0;
  assign end_conf = stub_end | spur_end;

  always @(negedge clk) begin
    if (rst) begin
      pend     = -1;
      stub_end = 1'b0;
    end else begin
      stub_end = (pend == cyc);
      if (init_conf && stub_en) pend = cyc + D;
    end
  end

  // ---------------- event observer ----------------
  int          init_q [$];
  int          done_q [$];
  int          ack_q  [$];
  int          erise_q[$];
  logic [23:0] word_q [$];
  bit          prev_err = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (init_conf) begin
        init_q.push_back(cyc);
        word_q.push_back(cfg_word);
      end
      if (done)     done_q.push_back(cyc);
      if (host_ack) ack_q.push_back(cyc);
      if (err && !prev_err) erise_q.push_back(cyc);
      prev_err = err;
    end else begin
      prev_err = 0;
    end
  end

  task automatic clear_q();
    init_q.delete(); done_q.delete(); ack_q.delete();
    erise_q.delete(); word_q.delete();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic host_wait(input int limit, input string nm);
    int k;
    k = 0;
    while (!host_ack && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(nm, host_ack, 1'b1);
    host_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s, h, fin, fin2;

    repeat (3) @(negedge clk);
    check("rst busy", busy, 1'b0);
    check("rst init_conf", init_conf, 1'b0);
    check("rst done", done, 1'b0);
    check("rst host_ack", host_ack, 1'b0);
    check("rst err", err, 1'b0);
    check("rst cfg_word", cfg_word, 24'h0);
    check("rst tbl_addr", tbl_addr, 4'h0);
    rst    = 1'b0;
    chk_en = 1;
    repeat (2) @(negedge clk);

    // spurious end_conf while idle
    spur_end = 1'b1;
    @(negedge clk);
    spur_end = 1'b0;
    repeat (3) @(negedge clk);
    check("idle after spurious end_conf", busy, 1'b0);

    // full table run
    clear_q();
    s = cyc;
    plan_table(s, fin);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(fin + 2);
    check("tbl init count", init_q.size(), 3);
    check("tbl init0 cycle", init_q[0], s + 3);
    check("tbl init1 cycle", init_q[1], s + 32);
    check("tbl init2 cycle", init_q[2], s + 61);
    check("tbl word0", word_q[0], 24'h000800);
    check("tbl word1", word_q[1], 24'h001403);
    check("tbl word2", word_q[2], 24'h00FF01);
    check("tbl done count", done_q.size(), 1);
    check("tbl done cycle", done_q[0], s + 88);
    check("tbl err", err, 1'b0);

    // host write with a spurious end_conf during GAP
    clear_q();
    h = cyc;
    plan_host(h, 24'h000D04, fin);
    host_word = 24'h000D04;
    host_req  = 1'b1;
    host_wait(10, "host ack seen");
    wait_until(h + 26);
    spur_end = 1'b1;
    @(negedge clk);
    spur_end = 1'b0;
    wait_until(fin + 2);
    check("host ack cycle", ack_q[0], h + 1);
    check("host init count", init_q.size(), 1);
    check("host init cycle", init_q[0], h + 1);
    check("host word", word_q[0], 24'h000D04);
    check("host done cycle", done_q[0], h + 28);

    // start and host_req together: table first, host afterwards
    clear_q();
    s = cyc;
    plan_table(s, fin);
    plan_host(fin + 1, 24'h00AB12, fin2);
    host_word = 24'h00AB12;
    host_req  = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    host_wait(200, "deferred host ack seen");
    wait_until(fin2 + 2);
    check("both ack count", ack_q.size(), 1);
    check("both ack cycle", ack_q[0], s + 90);
    check("both init count", init_q.size(), 4);
    check("both last word", word_q[3], 24'h00AB12);
    check("both done count", done_q.size(), 2);

    // timeout: serializer never answers
    clear_q();
    stub_en = 0;
    s = cyc;
    plan_timeout(s, fin);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(fin + 4);
    check("tmo err rise cycle", erise_q[0], s + 67);
    check("tmo init count", init_q.size(), 1);
    check("tmo done cycle", done_q[0], s + 67);
    check("tmo err sticky", err, 1'b1);
    stub_en = 1;

    // next start clears err
    clear_q();
    s = cyc;
    plan_table(s, fin);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err cleared by start", err, 1'b0);
    wait_until(fin + 2);
    check("rerun done count", done_q.size(), 1);

    // reset during WAIT of entry 1
    clear_q();
    s = cyc;
    plan_table(s, fin);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(s + 40);
    @(posedge clk);
    #2;
    rst = 1'b1;
    clear_from(cyc);
    #1;
    check("mid rst busy", busy, 1'b0);
    check("mid rst init_conf", init_conf, 1'b0);
    check("mid rst done", done, 1'b0);
    check("mid rst err", err, 1'b0);
    check("mid rst cfg_word", cfg_word, 24'h0);
    check("mid rst tbl_addr", tbl_addr, 4'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("mid rst no done", done_q.size(), 0);
    check("mid rst init count", init_q.size(), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
